// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams bytes over a valid/ready handshake, packs them
// little-endian into 32-bit words, and writes each word into instruction
// memory with a single-cycle strobe. The core is held in reset (core_hold)
// until the whole program is in memory.
//
// Optional build macro LOADER_CHECKSUM_EN: after the last word the loader
// accepts one trailing checksum byte (XOR of all data bytes). On a mismatch,
// err is raised and the core stays held in reset.
module imem_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  // State entered once the final word (or an empty load) has been handled.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_NEXT = CHK;
`else
  localparam state_t LAST_NEXT = DONE;
`endif

  // Largest load that fits the memory; longer requests are clamped to it.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         asm_q, asm_d;
  logic                core_hold_q, core_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  logic accept;
  logic last_word;

  // Handshake and write strobe are decoded straight from the state so a
  // byte can be taken in the same cycle the FSM enters RECV/CHK.
  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    byte_ready = (state_q == RECV) || (state_q == CHK);
`else
    byte_ready = (state_q == RECV);
`endif
    imem_we   = (state_q == WRITE);
    accept    = byte_valid && byte_ready;
    last_word = ({1'b0, word_idx_q} == (len_q - ONE_LEN));
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // A restart from DONE behaves exactly like a fresh start from IDLE.
        if (start) begin
          len_d      = (load_len > MAX_LEN) ? MAX_LEN : load_len;
          word_idx_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
          state_d    = (load_len == '0) ? LAST_NEXT : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          if (byte_idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // word_idx holds at the last word so it can never wrap.
        if (last_word) begin
          state_d = LAST_NEXT;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          byte_idx_d = '0;
          state_d    = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          err_d   = (byte_data != csum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Registered status outputs follow the next state so they line up with it.
  always_comb begin
    done_d      = (state_d == DONE);
`ifdef LOADER_CHECKSUM_EN
    busy_d      = (state_d == RECV) || (state_d == WRITE) || (state_d == CHK);
    core_hold_d = (state_d != DONE) || err_d;
`else
    busy_d      = (state_d == RECV) || (state_d == WRITE);
    core_hold_d = (state_d != DONE);
`endif
  end

  // FSM and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      core_hold_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      core_hold_q <= core_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  // Address and data come straight from flops; they are only meaningful
  // while imem_we is high.
  assign imem_addr  = {{(30 - ADDR_W){1'b0}}, word_idx_q, 2'b00};
  assign imem_wdata = asm_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
